// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline constants, reused by the fetch, decode and execute stages.
//   XLEN      : datapath/address width
//   NOP_INSTR : canonical NOP (addi x0,x0,0), inserted into bubbles
//   PC_STEP   : sequential PC increment in bytes
package riscv_pkg;

  localparam int unsigned XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_STEP   = 4;

endpackage : riscv_pkg

// File: rtl/if_id_register.sv
// IF/ID pipeline register: holds the fetched PC, instruction and valid bit.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   clear      : insert a bubble (pc=0, instr=NOP_INSTR, valid=0); wins over hold
//   hold       : keep current contents
//   pc_in      : PC of the instruction being fetched
//   instr_in   : instruction word being fetched
//   pc_out, instr_out, valid_out : registered IF/ID contents
module if_id_register #(
  parameter int unsigned XLEN      = riscv_pkg::XLEN,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            hold,
  input  logic [XLEN-1:0] pc_in,
  input  logic [31:0]     instr_in,
  output logic [XLEN-1:0] pc_out,
  output logic [31:0]     instr_out,
  output logic            valid_out
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_out    <= '0;
      instr_out <= NOP_INSTR;
      valid_out <= 1'b0;
    end else if (clear) begin
      pc_out    <= '0;
      instr_out <= NOP_INSTR;
      valid_out <= 1'b0;
    end else if (!hold) begin
      pc_out    <= pc_in;
      instr_out <= instr_in;
      valid_out <= 1'b1;
    end
  end

endmodule : if_id_register

// File: rtl/fetch_unit.sv
// Instruction-fetch stage feeding a combinational instruction_memory.
//   clk, reset       : rising-edge clock, asynchronous active-high reset
//   stall            : hold PC and IF/ID
//   flush            : replace IF/ID with a bubble
//   redirect_valid   : taken branch/jump; load word-aligned redirect_pc
//   redirect_pc      : branch/jump target (bits [1:0] ignored)
//   instruction_code : instruction word returned for read_address
//   read_address     : current PC
//   if_id_pc, if_id_instr, if_id_valid : IF/ID pipeline register outputs
module fetch_unit #(
  parameter int unsigned XLEN      = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic [31:0]     instruction_code,
  output logic [XLEN-1:0] read_address,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_instr,
  output logic            if_id_valid
);

  import riscv_pkg::*;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;

  // Redirect beats stall; a flush without stall still advances the PC.
  always_comb begin
    pc_next = pc;
    if (redirect_valid)
      pc_next = {redirect_pc[XLEN-1:2], 2'b00};
    else if (!stall)
      pc_next = pc + XLEN'(PC_STEP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc <= RESET_PC;
    else       pc <= pc_next;
  end

  assign read_address = pc;

  if_id_register #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk       (clk),
    .reset     (reset),
    .clear     (redirect_valid | flush),
    .hold      (stall),
    .pc_in     (pc),
    .instr_in  (instruction_code),
    .pc_out    (if_id_pc),
    .instr_out (if_id_instr),
    .valid_out (if_id_valid)
  );

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] instruction_code;
  logic [31:0] read_address;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference state: the architectural view of the stage.
  logic [31:0] m_pc, m_ipc, m_iinstr;
  logic        m_valid;

  always #5 clk = ~clk;

  // Memory model: combinational, content derived from the address.
  assign instruction_code = {16'hC0DE, read_address[15:0]};

  fetch_unit #(
    .XLEN      (32),
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .flush            (flush),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .instruction_code (instruction_code),
    .read_address     (read_address),
    .if_id_pc         (if_id_pc),
    .if_id_instr      (if_id_instr),
    .if_id_valid      (if_id_valid)
  );

  task automatic model_reset();
    m_pc = 32'h0; m_ipc = 32'h0; m_iinstr = 32'h13; m_valid = 1'b0;
  endtask

  // Advance one rising edge; model applies the priority rules to the
  // inputs present before the edge. Returns #1 after the edge.
  task automatic tick();
    logic [31:0] n_pc, n_ipc, n_ii;
    logic        n_v;
    n_pc = m_pc; n_ipc = m_ipc; n_ii = m_iinstr; n_v = m_valid;
    if (redirect_valid) begin
      n_pc = (redirect_pc / 4) * 4;
      n_ipc = 0; n_ii = 32'h13; n_v = 0;
    end else if (flush) begin
      n_ipc = 0; n_ii = 32'h13; n_v = 0;
      if (!stall) n_pc = m_pc + 4;
    end else if (!stall) begin
      n_ipc = m_pc; n_ii = {16'hC0DE, m_pc[15:0]}; n_v = 1; n_pc = m_pc + 4;
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_ipc = n_ipc; m_iinstr = n_ii; m_valid = n_v;
  endtask

  task automatic set_in(input logic s, input logic f, input logic r, input logic [31:0] rp);
    stall = s; flush = f; redirect_valid = r; redirect_pc = rp;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    #1;
    n_cmp++; if (read_address !== 32'h0) begin n_bad++; $display("FAIL reset_pc got=%h exp=%h", read_address, 32'h0); end
    n_cmp++; if (if_id_pc !== 32'h0) begin n_bad++; $display("FAIL reset_ifpc got=%h exp=%h", if_id_pc, 32'h0); end
    n_cmp++; if (if_id_instr !== 32'h13) begin n_bad++; $display("FAIL reset_instr got=%h exp=%h", if_id_instr, 32'h13); end
    n_cmp++; if (if_id_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", if_id_valid); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_free_run();
    set_in(0, 0, 0, 0);
    tick();
    n_cmp++; if (read_address !== 32'h4) begin n_bad++; $display("FAIL run1_ra got=%h exp=%h", read_address, 32'h4); end
    n_cmp++; if (if_id_pc !== 32'h0 || if_id_instr !== 32'hC0DE0000 || if_id_valid !== 1'b1) begin
      n_bad++; $display("FAIL run1_ifid got=%h/%h/%b exp=0/C0DE0000/1", if_id_pc, if_id_instr, if_id_valid); end
    tick();
    n_cmp++; if (read_address !== 32'h8) begin n_bad++; $display("FAIL run2_ra got=%h exp=%h", read_address, 32'h8); end
    n_cmp++; if (if_id_pc !== 32'h4 || if_id_instr !== 32'hC0DE0004) begin
      n_bad++; $display("FAIL run2_ifid got=%h/%h exp=4/C0DE0004", if_id_pc, if_id_instr); end
  endtask

  task automatic test_stall();
    set_in(1, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (read_address !== 32'h8 || if_id_pc !== 32'h4 || if_id_valid !== 1'b1) begin
        n_bad++; $display("FAIL stall_hold got=%h/%h/%b exp=8/4/1", read_address, if_id_pc, if_id_valid); end
    end
    set_in(0, 0, 0, 0);
    tick();
    n_cmp++; if (if_id_pc !== 32'h8 || if_id_instr !== 32'hC0DE0008 || read_address !== 32'hC) begin
      n_bad++; $display("FAIL stall_release got=%h/%h/%h exp=8/C0DE0008/C", if_id_pc, if_id_instr, read_address); end
  endtask

  task automatic test_redirect_over_stall();
    set_in(1, 1, 1, 32'h0000_0103);
    tick();
    n_cmp++; if (read_address !== 32'h100 || if_id_valid !== 1'b0 || if_id_instr !== 32'h13 || if_id_pc !== 32'h0) begin
      n_bad++; $display("FAIL redir_stall got=%h/%b/%h/%h exp=100/0/13/0", read_address, if_id_valid, if_id_instr, if_id_pc); end
    set_in(0, 0, 0, 0);
    tick();
    n_cmp++; if (if_id_pc !== 32'h100 || if_id_instr !== 32'hC0DE0100 || if_id_valid !== 1'b1) begin
      n_bad++; $display("FAIL redir_next got=%h/%h/%b exp=100/C0DE0100/1", if_id_pc, if_id_instr, if_id_valid); end
  endtask

  task automatic test_flush();
    set_in(0, 0, 1, 32'h10);
    tick();
    set_in(0, 1, 0, 0);
    tick();
    n_cmp++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h13 || read_address !== 32'h14) begin
      n_bad++; $display("FAIL flush got=%b/%h/%h exp=0/13/14", if_id_valid, if_id_instr, read_address); end
    set_in(0, 0, 0, 0);
    tick();
    n_cmp++; if (if_id_pc !== 32'h14 || if_id_valid !== 1'b1) begin
      n_bad++; $display("FAIL flush_next got=%h/%b exp=14/1", if_id_pc, if_id_valid); end
    set_in(1, 1, 0, 0);
    tick();
    n_cmp++; if (read_address !== 32'h18 || if_id_valid !== 1'b0) begin
      n_bad++; $display("FAIL flush_stall got=%h/%b exp=18/0", read_address, if_id_valid); end
    set_in(0, 0, 0, 0);
  endtask

  task automatic test_wrap();
    set_in(0, 0, 1, 32'hFFFF_FFFE);
    tick();
    n_cmp++; if (read_address !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_ra0 got=%h exp=FFFFFFFC", read_address); end
    set_in(0, 0, 0, 0);
    tick();
    n_cmp++; if (read_address !== 32'h0 || if_id_pc !== 32'hFFFF_FFFC || if_id_valid !== 1'b1 || if_id_instr !== 32'hC0DEFFFC) begin
      n_bad++; $display("FAIL wrap got=%h/%h/%b/%h exp=0/FFFFFFFC/1/C0DEFFFC", read_address, if_id_pc, if_id_valid, if_id_instr); end
  endtask

  task automatic test_back_to_back();
    set_in(0, 0, 1, 32'h200);
    tick();
    set_in(0, 0, 1, 32'h301);
    tick();
    n_cmp++; if (read_address !== 32'h300 || if_id_valid !== 1'b0) begin
      n_bad++; $display("FAIL b2b_redir got=%h/%b exp=300/0", read_address, if_id_valid); end
    set_in(0, 0, 0, 0);
    tick();
    n_cmp++; if (if_id_pc !== 32'h300 || if_id_valid !== 1'b1) begin
      n_bad++; $display("FAIL b2b_next got=%h/%b exp=300/1", if_id_pc, if_id_valid); end
  endtask

  task automatic test_async_reset();
    set_in(0, 0, 1, 32'h20);
    tick();
    set_in(0, 0, 0, 0);
    tick();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    n_cmp++; if (read_address !== 32'h0 || if_id_valid !== 1'b0 || if_id_instr !== 32'h13) begin
      n_bad++; $display("FAIL async_reset got=%h/%b/%h exp=0/0/13", read_address, if_id_valid, if_id_instr); end
    @(posedge clk); #1;
    reset = 1'b0;
    tick();
    n_cmp++; if (if_id_pc !== 32'h0 || if_id_valid !== 1'b1 || read_address !== 32'h4) begin
      n_bad++; $display("FAIL post_reset got=%h/%b/%h exp=0/1/4", if_id_pc, if_id_valid, read_address); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      set_in($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
             $urandom_range(0, 9) < 1, $urandom);
      tick();
      n_cmp++;
      if (read_address !== m_pc || if_id_pc !== m_ipc || if_id_instr !== m_iinstr || if_id_valid !== m_valid) begin
        n_bad++;
        $display("FAIL rand[%0d] got=%h/%h/%h/%b exp=%h/%h/%h/%b", i,
                 read_address, if_id_pc, if_id_instr, if_id_valid, m_pc, m_ipc, m_iinstr, m_valid);
      end
    end
    set_in(0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_free_run();
    test_stall();
    test_redirect_over_stall();
    test_flush();
    test_wrap();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_fetch_unit
